// File: rtl/scroll_message_ctrl.sv
// -----------------------------------------------------------------------------
// scroll_message_ctrl
//
// Scheduler for a 4-digit, 7-segment scan path. Holds a small buffer of 4-bit
// character codes and time-multiplexes a scrolling 4-character window onto the
// active-low anodes an3..an0 (an3 is the leftmost digit).
//
// Every digit slot is DIGIT_CYCLES clkdv cycles long. The first cycle of a slot
// is a blank/load cycle: all anodes are off and the character for the slot is
// fetched into out. The remaining DIGIT_CYCLES-1 cycles light only that digit.
// Blanking between digits stops the previous digit's code from ghosting onto
// the next one.
//
// After SCROLL_SCANS complete 4-digit scans the window start (offset) advances
// by one character, modulo the latched message length. wrap pulses for one
// cycle whenever offset returns to 0.
//
// Parameters
//   MSG_DEPTH     buffer entries (power of 2, 2..16)
//   DIGIT_CYCLES  clkdv cycles per digit slot (1 load + lit cycles), >= 2
//   SCROLL_SCANS  complete scans per one-character scroll step, >= 1
//
// Ports
//   clkdv    in   scan clock; all logic runs on its rising edge
//   reset    in   asynchronous, active-low reset
//   wr_en    in   buffer write strobe, accepted in any state
//   wr_addr  in   buffer write index; indices >= MSG_DEPTH are dropped
//   wr_data  in   character code to store
//   msg_len  in   message length in characters, latched when scanning starts
//   run      in   level: 1 = scroll/display, 0 = return to idle
//   an3..an0 out  digit anodes, active-low
//   out      out  character code for the currently enabled digit
//   busy     out  1 while scanning
//   wrap     out  one-cycle pulse when the scroll offset returns to 0
// -----------------------------------------------------------------------------
module scroll_message_ctrl #(
    parameter int MSG_DEPTH    = 16,
    parameter int DIGIT_CYCLES = 4,
    parameter int SCROLL_SCANS = 64
) (
    input  logic       clkdv,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [4:0] msg_len,
    input  logic       run,
    output logic       an3,
    output logic       an2,
    output logic       an1,
    output logic       an0,
    output logic [3:0] out,
    output logic       busy,
    output logic       wrap
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int SW = $clog2(SCROLL_SCANS) + 1;

    localparam logic [CW-1:0] CYC_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCROLL_SCANS - 1);
    localparam logic [4:0]    DEPTH_LEN = 5'(MSG_DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Message buffer. Cleared by reset, so it is kept in flops rather than a
    // RAM. Each entry decodes its own write enable; an out-of-range wr_addr
    // simply matches no entry and the write is dropped.
    // -------------------------------------------------------------------------
    logic [3:0] msg_mem [MSG_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < MSG_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clkdv or negedge reset) begin
                if (!reset) begin
                    msg_mem[gi] <= 4'b0000;
                end else if (wr_en && (wr_addr == 4'(gi))) begin
                    msg_mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Scan state
    // -------------------------------------------------------------------------
    state_t         state_reg;
    logic [4:0]     len_reg;      // latched message length, 1..MSG_DEPTH
    logic [AW-1:0]  offset_reg;   // buffer index shown on an3
    logic [AW-1:0]  ptr_reg;      // buffer index for the current slot
    logic [1:0]     slot_reg;     // 0 = an3 .. 3 = an0
    logic [CW-1:0]  cyc_reg;      // cycle within slot, 0 = load cycle
    logic [SW-1:0]  scan_reg;     // completed scans since last scroll step
    logic [3:0]     anodes_reg;   // {an3, an2, an1, an0}
    logic [3:0]     out_reg;
    logic           busy_reg;
    logic           wrap_reg;

    // Successor helpers. Both pointers walk the buffer modulo len_reg, which
    // also makes a short message repeat across the four digits.
    logic           cyc_last;
    logic           slot_last;
    logic           scan_done;
    logic           scroll_step;
    logic [4:0]     ptr_plus;
    logic [4:0]     offset_plus;
    logic [AW-1:0]  ptr_inc;
    logic [AW-1:0]  offset_inc;
    logic [AW-1:0]  offset_next;
    logic [4:0]     len_clamped;

    always_comb begin
        cyc_last    = (cyc_reg == CYC_LAST);
        slot_last   = (slot_reg == 2'd3);
        scan_done   = cyc_last && slot_last;
        scroll_step = scan_done && (scan_reg == SCAN_LAST);

        ptr_plus    = 5'(ptr_reg) + 5'd1;
        offset_plus = 5'(offset_reg) + 5'd1;
        ptr_inc     = (ptr_plus == len_reg) ? '0 : AW'(ptr_plus);
        offset_inc  = (offset_plus == len_reg) ? '0 : AW'(offset_plus);
        offset_next = scroll_step ? offset_inc : offset_reg;

        len_clamped = (msg_len > DEPTH_LEN) ? DEPTH_LEN : msg_len;
    end

    // -------------------------------------------------------------------------
    // Controller FSM. Every output is registered and describes the cycle that
    // follows the edge, so the anode pattern is computed from the position
    // the counters move to.
    // -------------------------------------------------------------------------
    always_ff @(posedge clkdv or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            len_reg    <= 5'd0;
            offset_reg <= '0;
            ptr_reg    <= '0;
            slot_reg   <= 2'd0;
            cyc_reg    <= '0;
            scan_reg   <= '0;
            anodes_reg <= 4'b1111;
            out_reg    <= 4'b0000;
            busy_reg   <= 1'b0;
            wrap_reg   <= 1'b0;
        end else begin
            wrap_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    anodes_reg <= 4'b1111;
                    busy_reg   <= 1'b0;
                    if (run && (msg_len != 5'd0)) begin
                        state_reg  <= ST_SCAN;
                        len_reg    <= len_clamped;
                        offset_reg <= '0;
                        ptr_reg    <= '0;
                        slot_reg   <= 2'd0;
                        cyc_reg    <= '0;
                        scan_reg   <= '0;
                        busy_reg   <= 1'b1;
                    end
                end

                ST_SCAN: begin
                    if (!run) begin
                        state_reg  <= ST_IDLE;
                        offset_reg <= '0;
                        ptr_reg    <= '0;
                        slot_reg   <= 2'd0;
                        cyc_reg    <= '0;
                        scan_reg   <= '0;
                        anodes_reg <= 4'b1111;
                        busy_reg   <= 1'b0;
                    end else begin
                        // Load: the buffer read sees the value from before a
                        // write landing on this same edge.
                        if (cyc_reg == '0) begin
                            out_reg <= msg_mem[ptr_reg];
                        end

                        if (cyc_last) begin
                            // Slot ends: next cycle is the following slot's
                            // blank/load cycle.
                            cyc_reg    <= '0;
                            slot_reg   <= slot_reg + 2'd1;
                            anodes_reg <= 4'b1111;
                            ptr_reg    <= slot_last ? offset_next : ptr_inc;
                        end else begin
                            // Light only this slot's digit (an3 is bit 3).
                            cyc_reg    <= cyc_reg + CW'(1);
                            anodes_reg <= ~(4'b1000 >> slot_reg);
                        end

                        if (scan_done) begin
                            if (scroll_step) begin
                                scan_reg   <= '0;
                                offset_reg <= offset_inc;
                                wrap_reg   <= (offset_inc == '0);
                            end else begin
                                scan_reg <= scan_reg + SW'(1);
                            end
                        end
                    end
                end

                default: begin
                    state_reg  <= ST_IDLE;
                    anodes_reg <= 4'b1111;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign an3  = anodes_reg[3];
    assign an2  = anodes_reg[2];
    assign an1  = anodes_reg[1];
    assign an0  = anodes_reg[0];
    assign out  = out_reg;
    assign busy = busy_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_scroll_message_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for scroll_message_ctrl. The reference model tracks the time since
// scanning started and derives slot, digit, offset and wrap from it with plain
// arithmetic; the buffer is a simple array updated on write strobes.
// -----------------------------------------------------------------------------
module tb_scroll_message_ctrl;

    localparam int DC = 4;             // DIGIT_CYCLES
    localparam int SS = 2;             // SCROLL_SCANS
    localparam int P  = 4 * DC * SS;   // cycles per scroll step

    logic       clkdv = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] msg_len;
    logic       run;
    logic       an3, an2, an1, an0;
    logic [3:0] out;
    logic       busy;
    logic       wrap;

    scroll_message_ctrl #(
        .MSG_DEPTH   (16),
        .DIGIT_CYCLES(DC),
        .SCROLL_SCANS(SS)
    ) dut (
        .clkdv  (clkdv),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .msg_len(msg_len),
        .run    (run),
        .an3    (an3),
        .an2    (an2),
        .an1    (an1),
        .an0    (an0),
        .out    (out),
        .busy   (busy),
        .wrap   (wrap)
    );

    always #5 clkdv = ~clkdv;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_scan = 1'b0;
    int         m_t    = 0;      // cycles since the first SCAN cycle
    int         m_len  = 1;
    logic [3:0] m_buf [16];
    logic [3:0] m_out  = 4'h0;

    logic [3:0] an_vec;
    logic [9:0] dut_vec;
    assign an_vec  = {an3, an2, an1, an0};
    assign dut_vec = {an3, an2, an1, an0, out, busy, wrap};

    // Expected {anodes, out, busy, wrap} for the current cycle.
    function automatic logic [9:0] exp_vec();
        logic [3:0] an;
        logic       wr;
        logic [3:0] sel;
        an = 4'hF;
        wr = 1'b0;
        if (m_scan) begin
            if (m_t % DC != 0) begin
                sel = 4'b1000 >> ((m_t / DC) % 4);
                an  = ~sel;
            end
            wr = (m_t > 0) && (m_t % P == 0) && (((m_t / P) % m_len) == 0);
        end
        return {an, m_out, m_scan, wr};
    endfunction

    // Advance one clock and apply the same edge to the model.
    task automatic step();
        @(posedge clkdv);
        if (reset) begin
            if (!m_scan) begin
                if (run && msg_len != 5'd0) begin
                    m_scan = 1'b1;
                    m_t    = 0;
                    m_len  = (msg_len > 5'd16) ? 16 : int'(msg_len);
                end
            end else if (!run) begin
                m_scan = 1'b0;
            end else begin
                if (m_t % DC == 0)
                    m_out = m_buf[(((m_t / P) % m_len) + ((m_t / DC) % 4)) % m_len];
                m_t++;
            end
            if (wr_en) m_buf[wr_addr] = wr_data;
        end
        #1;
    endtask

    task automatic write_buf(input int a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic go_idle();
        run = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || an_vec !== 4'hF) begin
            errors++;
            $display("FAIL go_idle got busy=%b an=%b required busy=0 an=1111", busy, an_vec);
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 4'h0;
        msg_len = 5'd0; run = 1'b0;
        for (int i = 0; i < 16; i++) m_buf[i] = 4'h0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (an_vec !== 4'hF) begin errors++; $display("FAIL reset_an got=%b required=1111", an_vec); end
        checks++;
        if (out !== 4'h0) begin errors++; $display("FAIL reset_out got=%h required=0", out); end
        checks++;
        if (busy !== 1'b0 || wrap !== 1'b0) begin
            errors++; $display("FAIL reset_busy_wrap got=%b%b required=00", busy, wrap);
        end
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (dut_vec !== 10'b1111_0000_0_0) begin
                errors++; $display("FAIL idle_hold cycle=%0d got=%b required=1111000000", i, dut_vec);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_display();
        int d;
        for (int i = 0; i < 4; i++) write_buf(i, 4'(i + 1));
        msg_len = 5'd4;
        run     = 1'b1;
        for (int i = 0; i < P; i++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL display t=%0d got=%b required=%b", m_t, dut_vec, exp_vec());
            end
            checks++;
            if ($countones(~an_vec) > 1) begin
                errors++; $display("FAIL display_onehot t=%0d got an=%b required at most one low", m_t, an_vec);
            end
            d = -1;
            for (int k = 0; k < 4; k++) if (an_vec[3 - k] == 1'b0) d = k;
            if (d >= 0) begin
                checks++;
                if (out !== 4'(d + 1)) begin
                    errors++; $display("FAIL display_digit digit=%0d got=%h required=%h", d, out, d + 1);
                end
            end
        end
        go_idle();
        $display("test_display done");
    endtask

    task automatic test_scroll();
        int wraps;
        wraps = 0;
        for (int i = 0; i < 6; i++) write_buf(i, 4'(i + 1));
        msg_len = 5'd6;
        run     = 1'b1;
        for (int i = 0; i < 6 * P + 40; i++) begin
            step();
            if (wrap === 1'b1) wraps++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL scroll t=%0d got=%b required=%b", m_t, dut_vec, exp_vec());
            end
        end
        checks++;
        if (wraps != 1) begin errors++; $display("FAIL scroll_wrap_count got=%0d required=1", wraps); end
        go_idle();
        $display("test_scroll done");
    endtask

    task automatic test_short();
        int d;
        write_buf(0, 4'h7);
        write_buf(1, 4'h9);
        msg_len = 5'd2;
        run     = 1'b1;
        for (int i = 0; i < P; i++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL short t=%0d got=%b required=%b", m_t, dut_vec, exp_vec());
            end
            d = -1;
            for (int k = 0; k < 4; k++) if (an_vec[3 - k] == 1'b0) d = k;
            if (d >= 0) begin
                checks++;
                if (out !== ((d % 2 == 0) ? 4'h7 : 4'h9)) begin
                    errors++; $display("FAIL short_digit digit=%0d got=%h required=%h", d, out, (d % 2 == 0) ? 7 : 9);
                end
            end
        end
        go_idle();
        msg_len = 5'd0;
        run     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || an_vec !== 4'hF) begin
                errors++; $display("FAIL zero_len got busy=%b an=%b required busy=0 an=1111", busy, an_vec);
            end
        end
        run = 1'b0;
        step();
        $display("test_short done");
    endtask

    task automatic test_midscan_write();
        int guard;
        for (int i = 0; i < 4; i++) write_buf(i, 4'(i + 1));
        msg_len = 5'd4;
        run     = 1'b1;
        step();
        guard = 0;
        while (m_t != DC && guard < 20) begin step(); guard++; end
        checks++;
        if (m_t != DC) begin errors++; $display("FAIL midscan_reach got t=%0d required=%0d", m_t, DC); end
        // Current cycle is the an2 load cycle; write lands on its closing edge.
        wr_en = 1'b1; wr_addr = 4'h1; wr_data = 4'hF;
        step();
        wr_en   = 1'b0;
        msg_len = 5'd1;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL midscan t=%0d got=%b required=%b", m_t, dut_vec, exp_vec());
            end
            if (m_t == DC + 1) begin
                checks++;
                if (out !== 4'h2) begin errors++; $display("FAIL midscan_old got=%h required=2", out); end
            end
            if (m_t == 5 * DC + 1) begin
                checks++;
                if (out !== 4'hF) begin errors++; $display("FAIL midscan_new got=%h required=f", out); end
            end
            step();
        end
        go_idle();
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL relatch t=%0d got=%b required=%b", m_t, dut_vec, exp_vec());
            end
            if (m_scan && m_t % DC != 1 && m_t % DC != 0 || m_t % DC == 1) begin
                checks++;
                if (m_t >= 1 && out !== 4'h1) begin
                    errors++; $display("FAIL relatch_len1 t=%0d got=%h required=1", m_t, out);
                end
            end
        end
        go_idle();
        $display("test_midscan_write done");
    endtask

    task automatic test_stop_reset();
        msg_len = 5'd4;
        run     = 1'b1;
        for (int i = 0; i < 7; i++) step();
        run = 1'b0;
        step();
        checks++;
        if (an_vec !== 4'hF || busy !== 1'b0) begin
            errors++; $display("FAIL stop_mid_slot got an=%b busy=%b required an=1111 busy=0", an_vec, busy);
        end
        run = 1'b1;
        for (int i = 0; i < 10; i++) step();
        #2 reset = 1'b0;
        m_scan = 1'b0; m_t = 0; m_out = 4'h0;
        for (int i = 0; i < 16; i++) m_buf[i] = 4'h0;
        #1;
        checks++;
        if (dut_vec !== 10'b1111_0000_0_0) begin
            errors++; $display("FAIL async_reset got=%b required=1111000000", dut_vec);
        end
        step();
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL post_reset t=%0d got=%b required=%b", m_t, dut_vec, exp_vec());
            end
            checks++;
            if (out !== 4'h0) begin errors++; $display("FAIL post_reset_buf got=%h required=0", out); end
        end
        go_idle();
        $display("test_stop_reset done");
    endtask

    task automatic test_random();
        logic [3:0] prev_an;
        prev_an = 4'hF;
        for (int i = 0; i < 16; i++) write_buf(i, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 800; i++) begin
            wr_en   = ($urandom_range(0, 9) < 3);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 4'($urandom_range(0, 15));
            msg_len = 5'($urandom_range(0, 20));
            if ($urandom_range(0, 99) < 3) run = ~run;
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random i=%0d t=%0d got=%b required=%b", i, m_t, dut_vec, exp_vec());
            end
            checks++;
            if ($countones(~an_vec) > 1 ||
                (an_vec != 4'hF && prev_an != 4'hF && an_vec != prev_an)) begin
                errors++; $display("FAIL random_anode i=%0d got=%b prev=%b required single steady digit", i, an_vec, prev_an);
            end
            prev_an = an_vec;
        end
        wr_en = 1'b0;
        go_idle();
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_display();
        test_scroll();
        test_short();
        test_midscan_write();
        test_stop_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
